// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller and its datapath:
// FSM states, opcodes, and every control-field encoding the datapath decodes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format depends only on the opcode, so the datapath sees it in every state.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: instruction fields and status in,
// mux selects, enables and memory handshake out.
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal_instr
  );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALUOp plus instruction funct bits onto the ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op_b5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) uses bit 30 for sub; addi must never become sub.
          3'b000:  alu_control_o = (op_b5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: registered state, combinational control
// outputs, wait-state aware handshake with the unified memory port.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master ctrl
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic [2:0] alu_control;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] src_a, src_b, result_src;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    src_a      = SRCA_PC;
    src_b      = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = ctrl.mem_ready;
        pc_write   = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a = SRCA_REG;
        src_b = SRCB_IMM;
        case (ctrl.op)
          OP_LOAD:  state_d = S_MEMREAD;
          OP_STORE: state_d = S_MEMWRITE;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ctrl.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe stays up through wait states; memory commits on mem_ready.
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ctrl.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = SRCA_REG;
        src_b   = SRCB_REG;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_REG;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        src_a      = SRCA_REG;
        src_b      = SRCB_REG;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = ctrl.Zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target latched in DECODE; ALU meanwhile forms OldPC+4 for rd.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (ctrl.funct3),
    .op_b5_i       (ctrl.op[5]),
    .funct7b5_i    (ctrl.funct7b5),
    .alu_control_o (alu_control)
  );

  // Enables are gated by reset itself so nothing commits while reset is held.
  assign ctrl.mem_req       = mem_req;
  assign ctrl.MemWrite      = mem_write & reset_n;
  assign ctrl.AdrSrc        = adr_src;
  assign ctrl.IRWrite       = ir_write  & reset_n;
  assign ctrl.PCWrite       = pc_write  & reset_n;
  assign ctrl.RegWrite      = reg_write & reset_n;
  assign ctrl.illegal_instr = illegal;
  assign ctrl.ImmSrc        = imm_src_for(ctrl.op);
  assign ctrl.ALUSrcA       = src_a;
  assign ctrl.ALUSrcB       = src_b;
  assign ctrl.ResultSrc     = result_src;
  assign ctrl.ALUControl    = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction model expands each instruction into the
// expected per-cycle control vectors, which are compared against the controller.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic mr;
    logic zero;
    ctl_t exp;
  } cyc_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clk;
  logic reset_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  bit   in_cycle = 0;

  multicycle_controller_if ifc ();

  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic ctl_t observed();
    ctl_t o;
    o.mem_req    = ifc.mem_req;
    o.MemWrite   = ifc.MemWrite;
    o.AdrSrc     = ifc.AdrSrc;
    o.IRWrite    = ifc.IRWrite;
    o.PCWrite    = ifc.PCWrite;
    o.RegWrite   = ifc.RegWrite;
    o.ImmSrc     = ifc.ImmSrc;
    o.ALUSrcA    = ifc.ALUSrcA;
    o.ALUSrcB    = ifc.ALUSrcB;
    o.ResultSrc  = ifc.ResultSrc;
    o.ALUControl = ifc.ALUControl;
    o.illegal    = ifc.illegal_instr;
    return o;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] op);
    if (op == SW)       return 2'b01;
    else if (op == BEQ) return 2'b10;
    else if (op == JAL) return 2'b11;
    else                return 2'b00;
  endfunction

  // Instruction semantics -> ALU operation (add 000, sub 001, and 010, or 011, slt 101).
  function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic is_sub;
    is_sub = (op == RT) && f7;
    if (f3 == 3'b000)      return is_sub ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) return 3'b101;
    else if (f3 == 3'b110) return 3'b011;
    else if (f3 == 3'b111) return 3'b010;
    else                   return 3'b000;
  endfunction

  function automatic ctl_t blank(input logic [6:0] op);
    ctl_t e;
    e        = '0;
    e.ImmSrc = imm_ref(op);
    return e;
  endfunction

  function automatic ctl_t fetch_gated(input logic [6:0] op);
    ctl_t e;
    e           = blank(op);
    e.mem_req   = 1'b1;
    e.ALUSrcB   = 2'b10;
    e.ResultSrc = 2'b10;
    return e;
  endfunction

  // Runs one instruction: wf fetch waits, wm data waits, zero_mode 0/1 forces Zero, 2 randomizes.
  // max_cyc >= 0 stops early (used to abort an instruction with reset).
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int wf, input int wm, input int zero_mode,
                           input int max_cyc);
    cyc_t q[$];
    cyc_t c;
    ctl_t e;
    logic z;
    for (int i = 0; i <= wf; i++) begin
      e = fetch_gated(op);
      e.IRWrite = (i == wf);
      e.PCWrite = (i == wf);
      c = '{(i == wf), 1'($urandom), e};
      q.push_back(c);
    end
    e = blank(op);
    e.ALUSrcA = 2'b01;
    e.ALUSrcB = 2'b01;
    e.illegal = !(op inside {LW, SW, RT, IT, BEQ, JAL});
    c = '{1'($urandom), 1'($urandom), e};
    q.push_back(c);
    if (op == LW || op == SW) begin
      e = blank(op);
      e.ALUSrcA = 2'b10;
      e.ALUSrcB = 2'b01;
      c = '{1'($urandom), 1'($urandom), e};
      q.push_back(c);
      for (int i = 0; i <= wm; i++) begin
        e = blank(op);
        e.mem_req  = 1'b1;
        e.AdrSrc   = 1'b1;
        e.MemWrite = (op == SW);
        c = '{(i == wm), 1'($urandom), e};
        q.push_back(c);
      end
      if (op == LW) begin
        e = blank(op);
        e.ResultSrc = 2'b01;
        e.RegWrite  = 1'b1;
        c = '{1'($urandom), 1'($urandom), e};
        q.push_back(c);
      end
    end else if (op == RT || op == IT || op == JAL) begin
      e = blank(op);
      if (op == JAL) begin
        e.ALUSrcA = 2'b01;
        e.ALUSrcB = 2'b10;
        e.PCWrite = 1'b1;
      end else begin
        e.ALUSrcA    = 2'b10;
        e.ALUSrcB    = (op == IT) ? 2'b01 : 2'b00;
        e.ALUControl = alu_ref(op, f3, f7);
      end
      c = '{1'($urandom), 1'($urandom), e};
      q.push_back(c);
      e = blank(op);
      e.RegWrite = 1'b1;
      c = '{1'($urandom), 1'($urandom), e};
      q.push_back(c);
    end else if (op == BEQ) begin
      z = (zero_mode < 2) ? 1'(zero_mode) : 1'($urandom);
      e = blank(op);
      e.ALUSrcA    = 2'b10;
      e.ALUControl = 3'b001;
      e.PCWrite    = z;
      c = '{1'($urandom), z, e};
      q.push_back(c);
    end

    foreach (q[k]) begin
      if (max_cyc >= 0 && k >= max_cyc) break;
      if (in_cycle) in_cycle = 0;
      else begin
        @(posedge clk);
        #1;
      end
      ifc.op        = op;
      ifc.funct3    = f3;
      ifc.funct7b5  = f7;
      ifc.mem_ready = q[k].mr;
      ifc.Zero      = q[k].zero;
      @(negedge clk);
      chk_cnt++;
      if (observed() !== q[k].exp)
        $display("FAIL %s op=%b cycle %0d: got %h want %h", name, op, k, observed(), q[k].exp);
      else pass_cnt++;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_cycle = 1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ifc.op        = LW;
    ifc.funct3    = 3'b000;
    ifc.funct7b5  = 1'b0;
    ifc.Zero      = 1'b0;
    ifc.mem_ready = 1'b1;
    #3;
    chk_cnt++;
    if (observed() !== fetch_gated(LW))
      $display("FAIL reset_initial: got %h want %h", observed(), fetch_gated(LW));
    else pass_cnt++;
    repeat (2) begin
      @(negedge clk);
      chk_cnt++;
      if (observed() !== fetch_gated(LW))
        $display("FAIL reset_hold: got %h want %h", observed(), fetch_gated(LW));
      else pass_cnt++;
    end
    release_reset();
  endtask

  task automatic test_rtype();
    run_instr("rtype_sub", RT, 3'b000, 1'b1, 0, 0, 2, -1);
  endtask

  task automatic test_lw_waits();
    run_instr("lw_wait2", LW, 3'b010, 1'b0, 0, 2, 2, -1);
  endtask

  task automatic test_sw();
    run_instr("sw", SW, 3'b010, 1'b0, 0, 0, 2, -1);
    run_instr("sw_wait", SW, 3'b010, 1'b0, 1, 2, 2, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", BEQ, 3'b000, 1'b0, 0, 0, 1, -1);
    run_instr("beq_not_taken", BEQ, 3'b000, 1'b0, 0, 0, 0, -1);
  endtask

  task automatic test_jal_illegal();
    run_instr("jal", JAL, 3'b000, 1'b0, 0, 0, 2, -1);
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 0, 0, 2, -1);
    run_instr("after_illegal", IT, 3'b111, 1'b0, 0, 0, 2, -1);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    logic [6:0] op;
    ops = '{LW, SW, RT, IT, BEQ, JAL, 7'b0};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 7'b0) op = 7'($urandom);
      run_instr("random", op, 3'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), 2, -1);
    end
  endtask

  task automatic test_reset_mid_write();
    // Stop in the first MEMWRITE wait cycle, then abort with reset.
    run_instr("sw_abort", SW, 3'b010, 1'b0, 0, 3, 2, 4);
    #2;
    ifc.mem_ready = 1'b1;
    reset_n       = 1'b0;
    #1;
    chk_cnt++;
    if (observed() !== fetch_gated(SW))
      $display("FAIL reset_mid_write_async: got %h want %h", observed(), fetch_gated(SW));
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (observed() !== fetch_gated(SW))
      $display("FAIL reset_mid_write_hold: got %h want %h", observed(), fetch_gated(SW));
    else pass_cnt++;
    release_reset();
    run_instr("after_abort", RT, 3'b110, 1'b0, 0, 0, 2, -1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_waits();
    test_sw();
    test_beq();
    test_jal_illegal();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences a multicycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal) over the shared-ALU, shared-memory datapath. Each instruction is split into Fetch/Decode/Execute/Writeback steps. Every cycle the controller drives the datapath's mux selects, write enables, immediate format and ALU operation. It handshakes with a single unified instruction/data memory port that may insert wait states.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode, from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  memory write strobe
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load instruction register and OldPC
- PCWrite  out  1  load PC from Result
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 register A
- ALUSrcB  out  2  ALU B select: 00 register B, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  Result select: 00 ALUOut, 01 Data register, 10 ALUResult
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse when the opcode is unsupported

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Every output not listed for a state is 0. ALUOp is internal: 00 add, 01 sub, 10 funct decode.
- **FETCH:** mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite both equal mem_ready.
  - Moves to DECODE on mem_ready; otherwise holds.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=00 (latches the branch target into ALUOut). Next state by op:
  - lw 0000011 / sw 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → FETCH with illegal_instr=1
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op is lw, MEMWRITE if sw.
- **MEMREAD:** mem_req=1, AdrSrc=1. Holds until mem_ready, then MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1, then FETCH.
- **MEMWRITE:** mem_req=1, AdrSrc=1, MemWrite=1. MemWrite stays asserted through wait states. On mem_ready, goes to FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1, then FETCH.
- **BEQ:** ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, then FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (rd = OldPC+4).
- **ImmSrc** is decoded combinationally from op in every state:
  - lw and 0010011 → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - otherwise → 00
- **ALU decoder:**
  - ALUOp 00 → 000; ALUOp 01 → 001.
  - ALUOp 10 decodes funct3:
    - 000 → 001 if op[5]&funct7b5, else 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000

## Timing
- State register only; all outputs are combinational from state, op, funct and Zero/mem_ready (Moore, except the PCWrite and IRWrite qualifiers).
- Reset: reset_n low forces state FETCH immediately, independent of clk. While reset is held, outputs show FETCH values, gated so that IRWrite=PCWrite=RegWrite=MemWrite=0 regardless of mem_ready. Release is synchronous to the next rising edge.
- Reset asserted mid-instruction aborts it; no further enables are issued.
- Cycles per instruction with mem_ready tied to 1: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- illegal_instr lasts exactly one cycle (the DECODE cycle).

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum
  - opcode constants
  - ALUOp, ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings
- The datapath reuses the ImmSrc and ALUControl constants.
- One sub-module, `alu_decoder`: combinational (ALUOp, funct3, op[5], funct7b5) → ALUControl.
- FSM next-state logic and output decode live in `multicycle_controller`.

## Test plan
- **Reset:** reset_n=0 mid-MEMWRITE → MemWrite drops to 0 asynchronously, state FETCH; after release with mem_ready=1, IRWrite=PCWrite=1 on the first cycle.
- **R-type:** op=0110011, funct3=000, funct7b5=1, mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB; total 4 cycles.
- **lw with two wait states:** op=0000011, mem_ready low for 2 cycles in MEMREAD → 7 cycles total; ImmSrc=00; ResultSrc=01 and RegWrite=1 in MEMWB.
- **sw:** op=0100011 → ImmSrc=01; MemWrite=1 and AdrSrc=1 only in MEMWRITE; RegWrite never asserted.
- **beq:** op=1100011 → PCWrite=1 in BEQ when Zero=1, 0 when Zero=0; ALUControl=001; 3 cycles.
- **jal then illegal:** op=1101111 → ImmSrc=11, PCWrite in JAL, RegWrite in ALUWB; next op=1111111 → illegal_instr pulses for 1 cycle, returns to FETCH with no enable asserted.
